// File: rtl/mac_pipe_param.sv
// Three-stage multiply-add pipeline: single-shot A*B+C or saturating
// accumulation of A*B, with selectable signed/unsigned arithmetic.
module mac_pipe_param #(
  parameter int WIDTH     = 8,
  parameter int ACC_GUARD = 4,
  parameter int SIGNED    = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               A,
  input  logic [WIDTH-1:0]               B,
  input  logic [WIDTH-1:0]               C,
  input  logic                           mode,
  input  logic                           acc_clear,
  output logic [2*WIDTH+ACC_GUARD-1:0]   DATA_OUT,
  output logic                           out_valid,
  output logic                           overflow
);

  localparam int   PW  = 2 * WIDTH;
  localparam int   AW  = PW + ACC_GUARD;
  localparam logic SGN = (SIGNED != 0) ? 1'b1 : 1'b0;

  function automatic logic [AW-1:0] ext_c(input logic [WIDTH-1:0] x);
    return {{(AW-WIDTH){SGN & x[WIDTH-1]}}, x};
  endfunction

  function automatic logic [AW-1:0] ext_p(input logic [PW-1:0] x);
    return {{ACC_GUARD{SGN & x[PW-1]}}, x};
  endfunction

  // Out of range when the guard bit of the widened sum disagrees with the result.
  function automatic logic sat_detect(input logic [AW:0] s);
    if (SGN) begin
      return s[AW] ^ s[AW-1];
    end else begin
      return s[AW];
    end
  endfunction

  function automatic logic [AW-1:0] sat_clamp(input logic [AW:0] s);
    if (!sat_detect(s)) begin
      return s[AW-1:0];
    end else if (SGN) begin
      return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      return {AW{1'b1}};
    end
  endfunction

  logic             v1_r, m1_r, clr1_r;
  logic [WIDTH-1:0] a1_r, b1_r, c1_r;
  logic             v2_r, m2_r, clr2_r;
  logic [PW-1:0]    p2_r;
  logic [WIDTH-1:0] c2_r;
  logic [AW-1:0]    acc_r;

  logic [PW-1:0]    a_x_s, b_x_s, prod_s;
  logic [AW-1:0]    p_ext_s, c_ext_s, base_s, single_s, clamp_s;
  logic [AW:0]      sum_s;
  logic             sat_s;

  // Stage 1: capture the incoming sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_r   <= 1'b0;
      m1_r   <= 1'b0;
      clr1_r <= 1'b0;
      a1_r   <= {WIDTH{1'b0}};
      b1_r   <= {WIDTH{1'b0}};
      c1_r   <= {WIDTH{1'b0}};
    end else begin
      v1_r   <= in_valid;
      m1_r   <= mode;
      clr1_r <= acc_clear;
      a1_r   <= A;
      b1_r   <= B;
      c1_r   <= C;
    end
  end

  // Multiply on operands pre-extended to the product width; the low PW bits
  // are the exact product in either signedness.
  always_comb begin
    a_x_s  = {{WIDTH{SGN & a1_r[WIDTH-1]}}, a1_r};
    b_x_s  = {{WIDTH{SGN & b1_r[WIDTH-1]}}, b1_r};
    prod_s = a_x_s * b_x_s;
  end

  // Stage 2: register the product alongside the delayed sideband.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2_r   <= 1'b0;
      m2_r   <= 1'b0;
      clr2_r <= 1'b0;
      p2_r   <= {PW{1'b0}};
      c2_r   <= {WIDTH{1'b0}};
    end else begin
      v2_r   <= v1_r;
      m2_r   <= m1_r;
      clr2_r <= clr1_r;
      p2_r   <= prod_s;
      c2_r   <= c1_r;
    end
  end

  // Stage 3 datapath: single-shot sum and saturating accumulate candidate.
  always_comb begin
    p_ext_s  = ext_p(p2_r);
    c_ext_s  = ext_c(c2_r);
    single_s = p_ext_s + c_ext_s;
    if (clr2_r) begin
      base_s = c_ext_s;
    end else begin
      base_s = acc_r;
    end
    sum_s   = {SGN & base_s[AW-1], base_s} + {SGN & p_ext_s[AW-1], p_ext_s};
    sat_s   = sat_detect(sum_s);
    clamp_s = sat_clamp(sum_s);
  end

  // Stage 3: result, accumulator and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      DATA_OUT  <= {AW{1'b0}};
      acc_r     <= {AW{1'b0}};
      overflow  <= 1'b0;
    end else if (v2_r) begin
      out_valid <= 1'b1;
      if (m2_r) begin
        DATA_OUT <= clamp_s;
        acc_r    <= clamp_s;
        if (sat_s) begin
          overflow <= 1'b1;
        end else if (clr2_r) begin
          overflow <= 1'b0;
        end else begin
          overflow <= overflow;
        end
      end else begin
        DATA_OUT <= single_s;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_pipe_param.sv
// Directed bench for mac_pipe_param: one unsigned and one signed instance
// sharing clock and reset.
module tb_mac_pipe_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        u_in_valid, u_mode, u_clr, u_out_valid, u_overflow;
  logic [7:0]  u_a, u_b, u_c;
  logic [19:0] u_data;
  logic        s_in_valid, s_mode, s_clr, s_out_valid, s_overflow;
  logic [7:0]  s_a, s_b, s_c;
  logic [19:0] s_data;

  int checks = 0;
  int errors = 0;

  mac_pipe_param #(.WIDTH(8), .ACC_GUARD(4), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(u_in_valid), .A(u_a), .B(u_b), .C(u_c),
    .mode(u_mode), .acc_clear(u_clr), .DATA_OUT(u_data), .out_valid(u_out_valid),
    .overflow(u_overflow)
  );

  mac_pipe_param #(.WIDTH(8), .ACC_GUARD(4), .SIGNED(1)) s_dut (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .A(s_a), .B(s_b), .C(s_c),
    .mode(s_mode), .acc_clear(s_clr), .DATA_OUT(s_data), .out_valid(s_out_valid),
    .overflow(s_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_u(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic m, input logic clr);
    u_in_valid = v; u_a = a; u_b = b; u_c = c; u_mode = m; u_clr = clr;
  endtask

  task automatic drive_s(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic m, input logic clr);
    s_in_valid = v; s_a = a; s_b = b; s_c = c; s_mode = m; s_clr = clr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_u(1'b1, 8'd7, 8'd9, 8'd3, 1'b1, 1'b1);
    drive_s(1'b1, 8'd7, 8'd9, 8'd3, 1'b1, 1'b1);
    tick(); tick(); tick();
    checks++;
    if (u_out_valid !== 1'b0 || u_data !== 20'd0 || u_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_u got v=%b d=%0d ov=%b want v=0 d=0 ov=0", u_out_valid, u_data, u_overflow);
    end
    checks++;
    if (s_out_valid !== 1'b0 || s_data !== 20'd0 || s_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_s got v=%b d=%0d ov=%b want v=0 d=0 ov=0", s_out_valid, s_data, s_overflow);
    end
    reset = 1'b0;
    drive_u(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive_s(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_mode0_single();
    drive_u(1'b1, 8'd3, 8'd4, 8'd5, 1'b0, 1'b0);
    tick();
    drive_u(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      checks++;
      if (u_out_valid !== (cyc == 3)) begin
        errors++;
        $display("FAIL single_valid cycle %0d got %b want %b", cyc, u_out_valid, (cyc == 3));
      end
      if (cyc >= 3) begin
        checks++;
        if (u_data !== 20'd17) begin
          errors++;
          $display("FAIL single_data cycle %0d got %0d want 17", cyc, u_data);
        end
      end
      if (cyc < 4) tick();
    end
  endtask

  task automatic test_back_to_back();
    logic        va [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  aa [4] = '{8'd1, 8'd255, 8'd0, 8'd2};
    logic [7:0]  ba [4] = '{8'd1, 8'd255, 8'd0, 8'd2};
    logic [7:0]  ca [4] = '{8'd1, 8'd255, 8'd0, 8'd0};
    logic [19:0] ex [4] = '{20'd2, 20'd65280, 20'd0, 20'd4};
    for (int t = 0; t < 6; t++) begin
      if (t < 4) drive_u(va[t], aa[t], ba[t], ca[t], 1'b0, 1'b0);
      else       drive_u(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      tick();
      if (t >= 2) begin
        checks++;
        if (u_out_valid !== va[t-2]) begin
          errors++;
          $display("FAIL b2b_valid k=%0d got %b want %b", t-2, u_out_valid, va[t-2]);
        end
        if (va[t-2]) begin
          checks++;
          if (u_data !== ex[t-2]) begin
            errors++;
            $display("FAIL b2b_data k=%0d got %0d want %0d", t-2, u_data, ex[t-2]);
          end
        end
      end
    end
  endtask

  task automatic test_accumulate();
    logic        ma [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        ka [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0]  aa [4] = '{8'd2, 8'd5, 8'd1, 8'd1};
    logic [7:0]  ba [4] = '{8'd3, 8'd5, 8'd1, 8'd1};
    logic [7:0]  ca [4] = '{8'd10, 8'd0, 8'd1, 8'd0};
    logic [19:0] ex [4] = '{20'd16, 20'd41, 20'd2, 20'd42};
    for (int t = 0; t < 6; t++) begin
      if (t < 4) drive_u(1'b1, aa[t], ba[t], ca[t], ma[t], ka[t]);
      else       drive_u(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      tick();
      if (t >= 2) begin
        checks++;
        if (u_out_valid !== 1'b1 || u_data !== ex[t-2] || u_overflow !== 1'b0) begin
          errors++;
          $display("FAIL acc k=%0d got v=%b d=%0d ov=%b want v=1 d=%0d ov=0",
                   t-2, u_out_valid, u_data, u_overflow, ex[t-2]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [19:0] e;
    logic        eo;
    for (int t = 0; t < 21; t++) begin
      if (t == 0)       drive_u(1'b1, 8'd255, 8'd255, 8'd0, 1'b1, 1'b1);
      else if (t < 18)  drive_u(1'b1, 8'd255, 8'd255, 8'd0, 1'b1, 1'b0);
      else if (t == 18) drive_u(1'b1, 8'd1, 8'd1, 8'd0, 1'b1, 1'b1);
      else              drive_u(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      tick();
      if (t >= 2) begin
        if (t - 2 < 16) begin
          e  = 20'((t - 1) * 65025);
          eo = 1'b0;
        end else if (t - 2 < 18) begin
          e  = 20'hFFFFF;
          eo = 1'b1;
        end else begin
          e  = 20'd1;
          eo = 1'b0;
        end
        checks++;
        if (u_out_valid !== 1'b1 || u_data !== e || u_overflow !== eo) begin
          errors++;
          $display("FAIL sat k=%0d got v=%b d=%0d ov=%b want v=1 d=%0d ov=%b",
                   t-2, u_out_valid, u_data, u_overflow, e, eo);
        end
      end
    end
  endtask

  task automatic test_signed();
    logic [19:0] e;
    logic        eo;
    for (int t = 0; t < 37; t++) begin
      if (t == 0)      drive_s(1'b1, 8'hFD, 8'h04, 8'hFF, 1'b0, 1'b0);
      else if (t < 35) drive_s(1'b1, 8'h80, 8'h7F, 8'h00, 1'b1, (t == 1));
      else             drive_s(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      tick();
      if (t >= 2) begin
        if (t == 2) begin
          e  = 20'hFFFF3;
          eo = 1'b0;
        end else if (t - 2 <= 32) begin
          e  = 20'((t - 2) * -16256);
          eo = 1'b0;
        end else begin
          e  = 20'h80000;
          eo = 1'b1;
        end
        checks++;
        if (s_out_valid !== 1'b1 || s_data !== e || s_overflow !== eo) begin
          errors++;
          $display("FAIL signed k=%0d got v=%b d=%h ov=%b want v=1 d=%h ov=%b",
                   t-2, s_out_valid, s_data, s_overflow, e, eo);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 3; t++) begin
      drive_u(1'b1, 8'd255, 8'd255, 8'd0, 1'b1, 1'b0);
      drive_s(1'b1, 8'h80, 8'h7F, 8'h00, 1'b1, 1'b0);
      if (t == 2) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    drive_u(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive_s(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    for (int cyc = 3; cyc <= 5; cyc++) begin
      checks++;
      if (u_out_valid !== 1'b0 || u_data !== 20'd0 || u_overflow !== 1'b0 ||
          s_out_valid !== 1'b0 || s_data !== 20'd0 || s_overflow !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid cycle %0d got u(v=%b d=%0d ov=%b) s(v=%b d=%0d ov=%b) want all 0",
                 cyc, u_out_valid, u_data, u_overflow, s_out_valid, s_data, s_overflow);
      end
      if (cyc < 5) tick();
    end
    // Accumulator must restart from zero: no acc_clear, C ignored.
    drive_u(1'b1, 8'd1, 8'd1, 8'd9, 1'b1, 1'b0);
    drive_s(1'b1, 8'd1, 8'd1, 8'd9, 1'b1, 1'b0);
    tick();
    drive_u(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive_s(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    tick(); tick();
    checks++;
    if (u_out_valid !== 1'b1 || u_data !== 20'd1 || s_out_valid !== 1'b1 || s_data !== 20'd1) begin
      errors++;
      $display("FAIL rst_acc got u(v=%b d=%0d) s(v=%b d=%0d) want v=1 d=1",
               u_out_valid, u_data, s_out_valid, s_data);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_u(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive_s(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    test_reset();
    test_mode0_single();
    test_back_to_back();
    test_accumulate();
    test_saturation();
    test_signed();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_pipe_param.md
Name: mac_pipe_param

Overview:
- Parametrised 3-stage multiply-add pipeline. Successor to the fixed-width A*B+C datapath.
- Adds a valid handshake, selectable signed/unsigned arithmetic, and a per-sample mode: single-shot A*B+C or running accumulation of A*B seeded by C.
- Adds a saturating accumulator with a sticky overflow flag.
- Sits between the sample source and downstream processing in the same clock domain.

Parameters:
- WIDTH, 8, bit width of operands A, B, C.
- ACC_GUARD, 4, extra accumulator bits above 2*WIDTH. Must be >= 1.
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and result.

Ports:
- clk  in  1  rising-edge clock, single domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  A/B/C/mode/acc_clear are valid this cycle.
- A  in  WIDTH  multiplicand.
- B  in  WIDTH  multiplier.
- C  in  WIDTH  addend (mode 0) or accumulator seed (mode 1 with acc_clear).
- mode  in  1  0 = result is A*B+C; 1 = accumulate A*B.
- acc_clear  in  1  mode 1 only: reload the accumulator with C before adding A*B.
- DATA_OUT  out  2*WIDTH+ACC_GUARD  result.
- out_valid  out  1  DATA_OUT carries a new result this cycle.
- overflow  out  1  sticky accumulator saturation flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset). No asynchronous logic.
- Reset (when reset=1 at a rising edge):
  - All stage valid bits = 0, accumulator = 0, DATA_OUT = 0, out_valid = 0, overflow = 0.
  - In-flight samples are discarded.
  - reset has priority over every other input.
- Stage 1 (edge 1): register A, B, C, mode, acc_clear, in_valid.
- Stage 2 (edge 2): product P = A*B, 2*WIDTH bits, signed or unsigned per SIGNED. C, mode, acc_clear and valid are delayed alongside P.
- Stage 3 (edge 3):
  - If the stage-2 valid bit = 0: nothing changes except out_valid <= 0.
- Latency and throughput:
  - A sample presented with in_valid=1 in cycle 0 appears with out_valid=1 in cycle 3.
  - Throughput is one sample per clock. There is no stall or backpressure.
  - Bubbles (in_valid=0) propagate as out_valid=0.
- Width rules:
  - C and P are extended to 2*WIDTH+ACC_GUARD bits: zero-extended if SIGNED=0, sign-extended if SIGNED=1.
- Mode 0:
  - DATA_OUT = ext(P) + ext(C). This cannot overflow.
  - The accumulator is untouched.
  - acc_clear is ignored.
- Mode 1:
  - base = ext(C) if acc_clear, else the accumulator.
  - sum = base + ext(P), computed one bit wider than the accumulator.
  - If sum exceeds the representable range, clamp it: max (or min when SIGNED=1) and set overflow=1.
  - Accumulator <= the clamped sum; DATA_OUT <= the clamped sum.
- Mode is carried per sample. Mode 0 and mode 1 samples may interleave freely; mode 0 samples do not disturb the accumulator.
- overflow:
  - Sticky.
  - Cleared only by reset or by a valid mode-1 sample with acc_clear=1 whose own sum does not saturate.
  - It updates in the same cycle as the DATA_OUT that saturated.
- Output holding: DATA_OUT holds its last value while out_valid=0.

Test Plan:
- Mode 0 single sample (WIDTH=8, ACC_GUARD=4, SIGNED=0): A=3, B=4, C=5, in_valid=1 in cycle 0 -> DATA_OUT=17, out_valid=1 in cycle 3 only.
- Back-to-back stream with a bubble: (A,B,C) = (1,1,1), (255,255,255), idle cycle, (2,2,0) -> outputs 2, 65280, out_valid=0, then 4 in cycles 3, 4, 5, 6.
- Accumulate:
  - Mode 1, acc_clear=1, C=10, A=2, B=3 -> 16.
  - Then mode 1, A=5, B=5 -> 41.
  - Then a mode-0 sample (1,1,1) -> 2.
  - Then mode 1, A=1, B=1 -> 42 (accumulator untouched by the mode-0 sample).
- Saturation:
  - Mode 1, clear with C=0, then A=B=255 repeatedly.
  - 16th result = 1040400, overflow=0.
  - 17th result = 1048575, overflow=1, and it stays 1.
  - A later acc_clear sample with C=0, A=B=1 -> DATA_OUT=1, overflow=0.
- Signed (SIGNED=1): mode 0, A=0xFD (-3), B=4, C=0xFF (-1) -> DATA_OUT=0xFFFF3 (-13). Mode 1, repeated large negative products saturate to 0x80000 with overflow=1.
- Reset mid-operation: three valid samples issued, reset=1 in cycle 2 -> out_valid stays 0 in cycles 3-5, DATA_OUT=0, accumulator=0, overflow=0.
